// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte FIFO feeding the UART transmitter.
// Head entry is visible on rd_data whenever rd_empty=0; a one-cycle rd_req pops it.
// Status flags are registered from the next occupancy so they move with count.
module uart_tx_fifo #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned AF_LEVEL = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              almost_full,
  input  logic              rd_req,
  output logic              rd_empty,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
  logic [ADDR_W-1:0] rd_ptr, rd_ptr_nxt;
  logic [ADDR_W:0]   count_nxt;
  logic              full_nxt, almost_full_nxt, rd_empty_nxt;
  logic              overflow_nxt, underflow_nxt;
  logic              wr_ok, rd_ok, mem_we;

  // Acceptance is judged against the flags registered before this edge.
  assign wr_ok  = wr_en & ~full;
  assign rd_ok  = rd_req & ~rd_empty;
  assign mem_we = wr_ok & ~clr;

  // Head of queue falls through combinationally from the registered read pointer.
  assign rd_data = mem[rd_ptr];

  // Next-state: pointers, occupancy, flags derived from the next count, sticky errors.
  always_comb begin
    wr_ptr_nxt    = wr_ptr;
    rd_ptr_nxt    = rd_ptr;
    count_nxt     = count;
    overflow_nxt  = overflow;
    underflow_nxt = underflow;

    if (clr) begin
      wr_ptr_nxt    = '0;
      rd_ptr_nxt    = '0;
      count_nxt     = '0;
      overflow_nxt  = 1'b0;
      underflow_nxt = 1'b0;
    end else begin
      if (wr_ok) wr_ptr_nxt = wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr_nxt = rd_ptr + PTR_ONE;
      case ({wr_ok, rd_ok})
        2'b10:   count_nxt = count + ONE_C;
        2'b01:   count_nxt = count - ONE_C;
        default: count_nxt = count;
      endcase
      if (wr_en & full)      overflow_nxt  = 1'b1;
      if (rd_req & rd_empty) underflow_nxt = 1'b1;
    end

    full_nxt        = (count_nxt == DEPTH_C);
    almost_full_nxt = (count_nxt >= AF_C);
    rd_empty_nxt    = (count_nxt == '0);
  end

  // State register; reset discards contents immediately by zeroing occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      rd_empty    <= 1'b1;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      count       <= count_nxt;
      full        <= full_nxt;
      almost_full <= almost_full_nxt;
      rd_empty    <= rd_empty_nxt;
      overflow    <= overflow_nxt;
      underflow   <= underflow_nxt;
    end
  end

  // Storage array; contents are not reset and are don't-care while empty.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based reference model compared
// every falling edge, plus directed scenarios with literal expectations.
`timescale 1ns/100ps
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_req = 1'b0;
  logic       full, almost_full, rd_empty, overflow, underflow;
  logic [7:0] rd_data;
  logic [4:0] count;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference model state
  logic [7:0] m_q[$];
  bit         m_ovf = 1'b0;
  bit         m_udf = 1'b0;

  uart_tx_fifo #(.DATA_W(8), .ADDR_W(4), .AF_LEVEL(12)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .almost_full(almost_full),
    .rd_req(rd_req), .rd_empty(rd_empty), .rd_data(rd_data),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a plain FIFO queue with occupancy-based acceptance decided before the edge.
  always @(posedge clk or posedge rst) begin
    if (rst || clr) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      bit can_w, can_r;
      can_w = wr_en && (m_q.size() < 16);
      can_r = rd_req && (m_q.size() > 0);
      if (wr_en && !can_w) m_ovf = 1'b1;
      if (rd_req && !can_r) m_udf = 1'b1;
      if (can_r) void'(m_q.pop_front());
      if (can_w) m_q.push_back(wr_data);
    end
  end

  // Compare DUT against model mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count",       32'(count),       32'(m_q.size()));
      chk("rd_empty",    32'(rd_empty),    32'(m_q.size() == 0));
      chk("full",        32'(full),        32'(m_q.size() == 16));
      chk("almost_full", 32'(almost_full), 32'(m_q.size() >= 12));
      chk("overflow",    32'(overflow),    32'(m_ovf));
      chk("underflow",   32'(underflow),   32'(m_udf));
      if (m_q.size() > 0) chk("rd_data", 32'(rd_data), 32'(m_q[0]));
    end
  end

  // One clock of stimulus; returns 1 time unit after the edge that sampled it.
  task automatic drive(input bit w, input logic [7:0] d, input bit r, input bit c);
    wr_en = w; wr_data = d; rd_req = r; clr = c;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_req = 1'b0; clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rx;
    // 1. Reset then idle
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_empty", 32'(rd_empty), 32'd1);
    chk("rst_full",  32'(full),     32'd0);
    chk("rst_count", 32'(count),    32'd0);
    chk("rst_ovf",   32'(overflow), 32'd0);
    chk("rst_udf",   32'(underflow),32'd0);
    chk_en = 1'b1;
    drive(0, 8'h00, 0, 0);

    // 2. Single FWFT byte
    drive(1, 8'hA5, 0, 0);
    chk("fwft_empty", 32'(rd_empty), 32'd0);
    chk("fwft_data",  32'(rd_data),  32'hA5);
    chk("fwft_count", 32'(count),    32'd1);
    drive(0, 8'h00, 0, 0);
    drive(0, 8'h00, 1, 0);
    chk("pop_empty", 32'(rd_empty), 32'd1);
    chk("pop_count", 32'(count),    32'd0);

    // 3. Fill and overflow
    for (int i = 0; i < 16; i++) begin
      drive(1, 8'(i), 0, 0);
      if (i == 10) chk("af_low_11",  32'(almost_full), 32'd0);
      if (i == 11) chk("af_high_12", 32'(almost_full), 32'd1);
    end
    chk("fill_full",  32'(full),  32'd1);
    chk("fill_count", 32'(count), 32'd16);
    drive(1, 8'hFF, 0, 0);
    chk("ovf_set",   32'(overflow), 32'd1);
    chk("ovf_count", 32'(count),    32'd16);
    chk("model_sz16", 32'(m_q.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk("readback", 32'(rd_data), 32'(i));
      drive(0, 8'h00, 1, 0);
    end
    chk("drain_empty", 32'(rd_empty), 32'd1);
    chk("ovf_sticky",  32'(overflow), 32'd1);

    // 4. Simultaneous read+write at count=5 and at count=0
    drive(0, 8'h00, 0, 1);
    chk("clr_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 5; i++) drive(1, 8'(8'h50 + i), 0, 0);
    drive(1, 8'h55, 1, 0);
    chk("rw5_count", 32'(count),   32'd5);
    chk("rw5_head",  32'(rd_data), 32'h51);
    chk("model_sz5", 32'(m_q.size()), 32'd5);
    chk("rw5_tail",  32'(m_q[4]),  32'h55);
    drive(0, 8'h00, 0, 1);
    drive(1, 8'h66, 1, 0);
    chk("rw0_count", 32'(count),     32'd1);
    chk("rw0_udf",   32'(underflow), 32'd1);
    chk("rw0_data",  32'(rd_data),   32'h66);
    drive(0, 8'h00, 0, 1);

    // 5. Wrap-around streaming, depth+3 bytes
    for (int i = 0; i < 19; i++) begin
      drive(1, 8'(8'h30 + i), 0, 0);
      drive(0, 8'h00, 0, 0);
      if (rd_empty) begin
        chk("stream_avail", 32'(rd_empty), 32'd0);
      end else begin
        rx = rd_data;
        chk("stream_data", 32'(rx), 32'(8'h30 + i));
        drive(0, 8'h00, 1, 0);
      end
    end
    chk("stream_empty", 32'(rd_empty),  32'd1);
    chk("stream_ovf",   32'(overflow),  32'd0);
    chk("stream_udf",   32'(underflow), 32'd0);

    // 6. Clear with write, then async reset mid-stream
    for (int i = 0; i < 7; i++) drive(1, 8'(8'h70 + i), 0, 0);
    chk("pre_clr_count", 32'(count), 32'd7);
    drive(1, 8'h77, 0, 1);
    chk("clr_count", 32'(count),    32'd0);
    chk("clr_empty", 32'(rd_empty), 32'd1);
    chk("clr_af",    32'(almost_full), 32'd0);
    for (int i = 0; i < 3; i++) drive(1, 8'(8'h80 + i), 0, 0);
    chk("refill_count", 32'(count), 32'd3);
    #2 rst = 1'b1;
    #2;
    chk("arst_count", 32'(count),    32'd0);
    chk("arst_empty", 32'(rd_empty), 32'd1);
    chk("arst_full",  32'(full),     32'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    drive(1, 8'h99, 0, 0);
    chk("post_rst_data",  32'(rd_data), 32'h99);
    chk("post_rst_count", 32'(count),   32'd1);
    drive(0, 8'h00, 0, 0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
